fetch_unit: RTL



---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the 4-bit RISC core. Holds the program counter,
// drives the program memory address and registers the returned instruction
// into a valid/ready output stage consumed by decode.
//
// Handshake: ir_valid/ir_ready are strict valid/ready. An instruction
// transfers on a rising edge where ir_valid && ir_ready. While ir_valid is
// high and ir_ready is low, ir_data/ir_pc/ir_valid hold stable.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over everything)
//   imem_addr    program memory address, combinationally equal to pc
//   imem_data    instruction at imem_addr (zero-wait, same cycle)
//   ir_data      registered instruction to decode
//   ir_pc        address of ir_data
//   ir_valid     ir_data/ir_pc hold a live instruction
//   ir_ready     decode consumes the instruction this cycle
//   redir_valid  load redir_pc into pc and flush the output stage
//   redir_pc     redirect target
//   halted       fetch stopped on HALT_INSTR (also the FSM state: 1 = HALT)
//   fetch_count  saturating count of instructions loaded into the output stage
//   stall_count  saturating count of cycles with ir_valid && !ir_ready
//
// Build option
//   FETCH_PERF_CNT_EN  when defined, builds the two performance counters;
//                      otherwise fetch_count and stall_count are constant 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned              PC_WIDTH    = 4,
  parameter int unsigned              INSTR_WIDTH = 8,
  parameter logic [INSTR_WIDTH-1:0]   HALT_INSTR  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ir_data,
  output logic [PC_WIDTH-1:0]    ir_pc,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   redir_valid,
  input  logic [PC_WIDTH-1:0]    redir_pc,
  output logic                   halted,
  output logic [7:0]             fetch_count,
  output logic [7:0]             stall_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]  ir_data_q, ir_data_d;
  logic [PC_WIDTH-1:0]     ir_pc_q, ir_pc_d;
  logic                    ir_valid_q, ir_valid_d;
  logic                    load;
  logic                    stall;

  // A new instruction enters the output stage when running, the stage is
  // empty or draining this cycle, and no redirect is flushing it.
  assign load  = (state_q == ST_RUN) && (!ir_valid_q || ir_ready) && !redir_valid;
  assign stall = ir_valid_q && !ir_ready;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (redir_valid) begin
      // Redirect wins over any handshake in the same cycle; the instruction
      // being consumed is simply dropped.
      pc_d       = redir_pc;
      ir_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (load) begin
      ir_data_d  = imem_data;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      if (imem_data == HALT_INSTR) begin
        // The HALT word is still handed to decode; pc stays on it.
        state_d = ST_HALT;
      end else begin
        pc_d = pc_q + PC_WIDTH'(1);
      end
    end else if (ir_valid_q && ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir_data   = ir_data_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == ST_HALT);

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
  logic [7:0] fetch_cnt_q, fetch_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Saturate at all-ones; a redirect does not clear them.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load && (fetch_cnt_q != 8'hFF)) begin
      fetch_cnt_d = fetch_cnt_q + 8'd1;
    end
    if (stall && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 8'h00;
      stall_cnt_q <= 8'h00;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stall;
  assign fetch_count = 8'h00;
  assign stall_count = 8'h00;
`endif

endmodule
